barcode_tx: RTL and testbench

//  Transmit side of the barcode serial line: encodes an 8-bit ID onto BC in the format the

---
 rtl/barcode_tx.sv | 114 +++++++++++
 tb/tb_barcode_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/barcode_tx.sv
// Barcode line transmitter: start cell, 8 data cells MSB first, idle-high gap cell.
// Each cell opens with a falling edge. The length of the low pulse carries the cell's value.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, waiting for send
// S_START | start cell: low Hq, high Hq (sets the receiver's half period)
// S_BIT   | data cell for id_q[bit_idx]: '1' low Hq/2, '0' low 3Hq/2
// S_GAP   | line held high for one full cell, then done pulses
module barcode_tx #(
   parameter int HP_W = 22
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            send,
   input  logic [7:0]      ID,
   input  logic [HP_W-1:0] half_period,
   output logic            BC,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_GAP} state_t;

   state_t          state, state_nxt;
   logic [HP_W-1:0] hq, hq_nxt, hp_even;
   logic [7:0]      id_q, id_nxt;
   logic [2:0]      bit_idx, bit_idx_nxt;
   logic [HP_W:0]   cell_cnt, cnt_nxt, period, low_len, hq_x3_2;
   logic            cell_end, bc_nxt, done_nxt;

   // Quantised half period is even and never below 8. Period and 3Hq/2 get one extra bit.
   assign hp_even  = {half_period[HP_W-1:1], 1'b0};
   assign period   = {hq, 1'b0};
   assign cell_end = (cell_cnt == period - 1'b1);

   // Next-state logic. The cell counter restarts on every cell boundary.
   always_comb begin
      state_nxt   = state;
      hq_nxt      = hq;
      id_nxt      = id_q;
      bit_idx_nxt = bit_idx;
      cnt_nxt     = cell_cnt + 1'b1;
      done_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (send) begin
               hq_nxt    = (hp_even < HP_W'(8)) ? HP_W'(8) : hp_even;
               id_nxt    = ID;
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (cell_end) begin
               cnt_nxt     = '0;
               bit_idx_nxt = 3'd7;
               state_nxt   = S_BIT;
            end
         end
         S_BIT: begin
            if (cell_end) begin
               cnt_nxt = '0;
               if (bit_idx == 3'd0) state_nxt = S_GAP;
               else bit_idx_nxt = bit_idx - 3'd1;
            end
         end
         S_GAP: begin
            if (cell_end) begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // BC is registered, so its next value is derived from the next cell's low length and count.
   always_comb begin
      hq_x3_2 = {1'b0, hq_nxt} + {2'b00, hq_nxt[HP_W-1:1]};
      low_len = '0;
      case (state_nxt)
         S_START: low_len = {1'b0, hq_nxt};
         S_BIT:   low_len = id_nxt[bit_idx_nxt] ? {2'b00, hq_nxt[HP_W-1:1]} : hq_x3_2;
         default: low_len = '0;
      endcase
      bc_nxt = !(cnt_nxt < low_len);
   end

   // State, latched frame parameters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         hq       <= '0;
         id_q     <= '0;
         bit_idx  <= '0;
         cell_cnt <= '0;
         BC       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         hq       <= hq_nxt;
         id_q     <= id_nxt;
         bit_idx  <= bit_idx_nxt;
         cell_cnt <= cnt_nxt;
         BC       <= bc_nxt;
         busy     <= (state_nxt != S_IDLE);
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_barcode_tx.sv
// Scoreboard bench for barcode_tx: expected low widths and periods are queued on send.
// A line monitor measures the low widths and periods and compares them with the queue.
module tb_barcode_tx;

   localparam int HP_W = 22;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            send = 1'b0;
   logic [7:0]      ID = 8'h00;
   logic [HP_W-1:0] half_period = '0;
   logic            BC, busy, done;

   int n_checks = 0;
   int n_err    = 0;

   int q_low[$];
   int q_p[$];
   bit mon_en = 1'b0;

   barcode_tx #(.HP_W(HP_W)) dut (
      .clk(clk), .rst(rst), .send(send), .ID(ID), .half_period(half_period),
      .BC(BC), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int hq_of(input int h);
      int q;
      q = h & ~1;
      if (q < 8) q = 8;
      return q;
   endfunction

   task automatic push_frame(input logic [7:0] id, input int h);
      int hq;
      hq = hq_of(h);
      q_p.push_back(2 * hq);
      q_low.push_back(hq);
      for (int i = 7; i >= 0; i--)
         q_low.push_back(id[i] ? hq / 2 : (3 * hq) / 2);
   endtask

   // Line monitor, samples on the falling clock edge.
   initial begin : monitor
      int cyc, bc_prev, nfall, first_fall, last_fall, cur_p, low_cnt;
      cyc = 0; bc_prev = 1; nfall = 0; first_fall = 0; last_fall = 0; cur_p = 0; low_cnt = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!mon_en) begin
            bc_prev = 1; nfall = 0; low_cnt = 0;
            q_low.delete();
            q_p.delete();
         end else begin
            if (bc_prev == 1 && BC == 1'b0) begin
               if (nfall == 0) begin
                  chk("frame_expected", (q_p.size() > 0), 1);
                  cur_p = (q_p.size() > 0) ? q_p.pop_front() : 0;
                  first_fall = cyc;
               end else begin
                  chk("fall_spacing", cyc - last_fall, cur_p);
               end
               last_fall = cyc;
               nfall++;
               low_cnt = 0;
            end
            if (BC == 1'b0) low_cnt++;
            if (bc_prev == 0 && BC == 1'b1) begin
               chk("low_expected", (q_low.size() > 0), 1);
               if (q_low.size() > 0) chk("low_width", low_cnt, q_low.pop_front());
            end
            if (done) begin
               chk("frame_len", cyc - first_fall, 10 * cur_p);
               chk("falls_per_frame", nfall, 9);
               chk("busy_at_done", busy, 0);
               nfall = 0;
            end
            bc_prev = BC;
         end
      end
   end

   task automatic start_frame(input logic [7:0] id, input int h);
      @(negedge clk);
      ID = id;
      half_period = HP_W'(h);
      send = 1'b1;
      push_frame(id, h);
      @(negedge clk);
      send = 1'b0;
      chk("busy_after_send", busy, 1);
      chk("bc_after_send", BC, 0);
   endtask

   task automatic wait_done(input int budget);
      bit got;
      got = 0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      chk("done_seen", got, 1);
   endtask

   task automatic check_quiet(input string tag, input int ncyc);
      int bad;
      bad = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk);
         if (BC !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      chk(tag, bad, 0);
   endtask

   initial begin : main
      repeat (3) @(negedge clk);
      chk("reset_bc", BC, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      start_frame(8'hA5, 8);    wait_done(200);
      start_frame(8'h00, 8);    wait_done(200);
      start_frame(8'hFF, 8);    wait_done(200);
      check_quiet("idle_after_ff", 20);
      start_frame(8'h5A, 7);    wait_done(200);
      start_frame(8'h81, 9);    wait_done(200);
      start_frame(8'h3C, 1001); wait_done(20100);
      start_frame(8'h5A, 64);   wait_done(1400);

      // A send during a frame must be ignored and must not be queued.
      start_frame(8'hC3, 8);
      repeat (40) @(negedge clk);
      ID = 8'h0F; half_period = HP_W'(40); send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      wait_done(200);
      check_quiet("no_second_frame", 60);

      // Reset while a data cell is low.
      start_frame(8'h00, 8);
      mon_en = 1'b0;
      repeat (20) @(negedge clk);
      chk("pre_reset_low", BC, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_bc", BC, 1);
      chk("rst_mid_busy", busy, 0);
      check_quiet("no_done_after_rst", 40);
      mon_en = 1'b1;
      @(negedge clk);
      start_frame(8'h96, 8);    wait_done(200);

      // With send held high, frames run back-to-back.
      @(negedge clk);
      ID = 8'h6B; half_period = HP_W'(8); send = 1'b1;
      push_frame(8'h6B, 8);
      push_frame(8'h6B, 8);
      wait_done(200);
      wait_done(200);
      send = 1'b0;
      check_quiet("b2b_stop", 40);

      chk("low_queue_empty", q_low.size(), 0);
      chk("period_queue_empty", q_p.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
